// File: rtl/tts_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tts_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int NVEC(input int n);
        return 1 << n;
    endfunction

    // Cycles from an accepted start edge to the done cycle, inclusive of DONE.
    function automatic int SWEEP_CYCLES(input int n, input int d);
        return NVEC(n) * d + 1;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle of each dwell.
module dwell_timer #(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic term
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (clear)       cnt <= '0;
        else if (enable) begin
            if (cnt == LAST)  cnt <= '0;
            else              cnt <= cnt + 1'b1;
        end
    end

    assign term = enable && (cnt == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a stimulus vector through every input combination, captures the DUT response
// into a truth table and compares it against a golden table at the end of the sweep.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int DWELL = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     y_in,
    input  logic [NVEC(N_IN)-1:0]    expected,
    output logic [N_IN-1:0]          vec,
    output logic                     vec_valid,
    output logic                     busy,
    output logic [NVEC(N_IN)-1:0]    tt,
    output logic                     done,
    output logic                     match
);

    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    state_t                  state, state_d;
    logic [N_IN-1:0]         index, index_d, vec_d;
    logic [NVEC(N_IN)-1:0]   tt_d;
    logic                    vv_d, busy_d, done_d, match_d;
    logic                    term;

    // Dwell restarts on every entry into RUN and whenever a sweep is cancelled.
    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  ((state != RUN) || abort),
        .enable (state == RUN),
        .term   (term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (abort)                            state_d = IDLE;
                else if (term && (index == LAST_IDX)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs; abort takes priority over the final sample.
    always_comb begin
        index_d = index;
        vec_d   = vec;
        vv_d    = vec_valid;
        busy_d  = busy;
        tt_d    = tt;
        done_d  = 1'b0;
        match_d = match;
        unique case (state)
            IDLE: begin
                if (start) begin
                    index_d = '0;
                    vec_d   = '0;
                    vv_d    = 1'b1;
                    busy_d  = 1'b1;
                    tt_d    = '0;
                    match_d = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    vec_d  = '0;
                    vv_d   = 1'b0;
                    busy_d = 1'b0;
                end else if (term) begin
                    tt_d[index] = y_in;
                    if (index == LAST_IDX) begin
                        vec_d   = '0;
                        vv_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        match_d = (tt_d == expected);
                    end else begin
                        index_d = index + 1'b1;
                        vec_d   = index + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index     <= '0;
            vec       <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            tt        <= '0;
            done      <= 1'b0;
            match     <= 1'b0;
        end else begin
            index     <= index_d;
            vec       <= vec_d;
            vec_valid <= vv_d;
            busy      <= busy_d;
            tt        <= tt_d;
            done      <= done_d;
            match     <= match_d;
        end
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Upstream stimulus-and-capture stage for small combinational boolean blocks, synthesizable on-chip. On start, it steps an N-bit input vector through all 2^N combinations in ascending order and holds each for a programmable dwell. At the end of each dwell it samples the DUT's 1-bit output into a captured truth table. When the sweep finishes, it compares the captured table against an expected table and reports match, with a one-cycle done pulse.

Parameters:
N_IN, 3, width of the stimulus vector (DUT input count); legal range 1..6.
DWELL, 10, clock cycles each vector is held; legal range ≥1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  sweep request; sampled only in IDLE.
abort  input  1  cancels a running sweep.
y_in  input  1  DUT output under test.
expected  input  2^N_IN  golden truth table; bit i is the output for vector i; sampled at DONE.
vec  output  N_IN  stimulus to DUT; MSB drives the first DUT input (a).
vec_valid  output  1  vec is being driven as part of a sweep.
busy  output  1  sweep in progress.
tt  output  2^N_IN  captured truth table; bit i is y_in sampled for vector i.
done  output  1  one-cycle pulse at sweep completion.
match  output  1  tt == expected; valid from done until the next start.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Any rst_n low forces state IDLE and vec=0, vec_valid=0, busy=0, tt=0, done=0, match=0, with internal index=0 and dwell=0. This applies mid-sweep with no completion reported.
- States: IDLE, RUN, DONE.
- IDLE: outputs are held; tt and match keep their last values. If start=1 at an edge, next state is RUN with index=0, dwell=0, and tt cleared to 0. From the next cycle, vec=0, vec_valid=1, busy=1, match=0.
- RUN:
  - vec = index; dwell counts 0..DWELL-1.
  - At the edge where dwell==DWELL-1, tt[index] takes y_in and dwell returns to 0.
  - If index < 2^N_IN-1 at that edge, index increments and vec updates on the same edge.
  - If index == 2^N_IN-1 at that edge, next state is DONE.
  - With DWELL=1, sampling occurs at the end of the same cycle in which vec is presented; the DUT path must be combinational.
- DONE (exactly one cycle): done=1, busy=0, vec_valid=0, vec=0. match = (tt == expected), registered on entry so it is valid in the DONE cycle. Next state is IDLE.
- Latency: start accepted at edge k gives done high in cycle k+1+2^N_IN*DWELL. The next sweep can start from IDLE one cycle after done.
- abort: while in RUN, abort=1 at an edge returns to IDLE. vec_valid=0, busy=0, vec=0; no done pulse; match stays 0; tt retains the partial capture. If abort coincides with the final sample edge, abort wins and DONE is not entered. abort in IDLE or DONE is ignored.
- start while in RUN or DONE is ignored; it is not queued.
- Widths: index is N_IN bits wide. dwell is $clog2(DWELL+1) bits wide, with no wrap beyond DWELL-1. There is no index overflow, because the terminal test precedes increment.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package tts_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam function NVEC(n) = 1<<n;
  - sweep-length helper SWEEP_CYCLES(n,d) = NVEC(n)*d + 1, used by benches.
- One sub-module, dwell_timer. It takes clk, rst_n, clear, and enable, and produces a terminal pulse when the count reaches DWELL-1. The top holds the FSM, index, and tt capture.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release, no start -> all outputs 0 indefinitely.
- Full sweep: DUT y=(a&b)|c, N_IN=3, DWELL=10, expected=8'hEA, start pulse -> vec steps 0..7, each held 10 cycles; done in cycle k+81; tt=8'hEA; match=1.
- Mismatch: same DUT, expected=8'hE8 -> done at k+81; tt=8'hEA; match=0.
- Minimum dwell: DWELL=1, DUT y=a^b^c -> vec changes every cycle; done at k+9; tt=8'h96.
- Abort: start, then abort=1 during vector 4 -> next cycle busy=0, vec_valid=0; done never pulses; tt[7:4]=0; a fresh start then completes normally.
- Reset mid-sweep, plus start ignored during RUN: start pulses again during vector 2 -> no restart, done timing unchanged. In a separate run, rst_n low during vector 5 -> all outputs 0 immediately (asynchronous), with no done pulse.
